// File: rtl/determine_hit_unit_pkg.sv
// Shared constants and packed-vector slicing helpers for the four-entry
// hit/LRU lookup.
package determine_hit_unit_pkg;

  localparam int NUM_ENTRIES = 4;
  localparam int CNT_WIDTH   = 2;
  localparam int SEL_WIDTH   = 2;

  // LSB position of entry idx inside the packed address bus.
  function automatic int addr_lsb(input int idx, input int width);
    return idx * width;
  endfunction

  // LSB position of entry idx inside the packed LRU count bus.
  function automatic int cnt_lsb(input int idx);
    return idx * CNT_WIDTH;
  endfunction

endpackage

// File: rtl/determine_hit_core.sv
// Combinational lookup: tag compare, hit priority encode, free-slot / LRU
// victim search and decrement-request generation.
module determine_hit_core
  import determine_hit_unit_pkg::*;
#(
  parameter int a_width = 8
) (
  input  logic [a_width-1:0]             addr_in,
  input  logic [NUM_ENTRIES*a_width-1:0] w_addr,
  input  logic [NUM_ENTRIES*CNT_WIDTH-1:0] w_cnt,
  input  logic [NUM_ENTRIES-1:0]         valid,
  output logic                           hit_d,
  output logic [SEL_WIDTH-1:0]           sel_d,
  output logic [NUM_ENTRIES-1:0]         dec_d
);

  logic [NUM_ENTRIES-1:0] match;
  logic [NUM_ENTRIES-1:0] is_min;
  logic [CNT_WIDTH-1:0]   cnt_arr [NUM_ENTRIES];
  logic [CNT_WIDTH-1:0]   min_cnt;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [SEL_WIDTH-1:0] lowest_set(input logic [NUM_ENTRIES-1:0] v);
    logic [SEL_WIDTH-1:0] idx;
    idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (v[i]) idx = SEL_WIDTH'(i);
    end
    return idx;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      assign match[gi]   = valid[gi] &&
                           (w_addr[addr_lsb(gi, a_width) +: a_width] == addr_in);
      assign cnt_arr[gi] = w_cnt[cnt_lsb(gi) +: CNT_WIDTH];
    end
  endgenerate

  always_comb begin
    min_cnt = cnt_arr[0];
    for (int i = 1; i < NUM_ENTRIES; i++) begin
      if (cnt_arr[i] < min_cnt) min_cnt = cnt_arr[i];
    end
    is_min = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      is_min[i] = (cnt_arr[i] == min_cnt);
    end
  end

  always_comb begin
    hit_d = |match;
    sel_d = '0;
    dec_d = '0;
    if (hit_d) begin
      sel_d = lowest_set(match);
    end else if (!(&valid)) begin
      sel_d = lowest_set(~valid);
    end else begin
      sel_d = lowest_set(is_min);
    end
    // Entries more recent than the hit entry age by one step.
    if (hit_d) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        dec_d[i] = valid[i] && (cnt_arr[i] > cnt_arr[sel_d]) &&
                   (SEL_WIDTH'(i) != sel_d);
      end
    end
  end

endmodule

// File: rtl/determine_hit_unit.sv
// Four-entry hit/victim lookup with a single registered output stage;
// results appear one clock after the inputs are sampled.
module determine_hit_unit
  import determine_hit_unit_pkg::*;
#(
  parameter int a_width = 8
) (
  input  logic                             clk,
  input  logic                             clr,
  input  logic [a_width-1:0]               addr_in,
  input  logic [NUM_ENTRIES*a_width-1:0]   w_addr,
  input  logic [NUM_ENTRIES*CNT_WIDTH-1:0] w_cnt,
  input  logic [NUM_ENTRIES-1:0]           valid,
  output logic [SEL_WIDTH-1:0]             sel,
  output logic [NUM_ENTRIES-1:0]           dec,
  output logic                             hit
);

  logic                   hit_d, hit_q;
  logic [SEL_WIDTH-1:0]   sel_d, sel_q;
  logic [NUM_ENTRIES-1:0] dec_d, dec_q;

  determine_hit_core #(
    .a_width(a_width)
  ) u_core (
    .addr_in(addr_in),
    .w_addr (w_addr),
    .w_cnt  (w_cnt),
    .valid  (valid),
    .hit_d  (hit_d),
    .sel_d  (sel_d),
    .dec_d  (dec_d)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hit_q <= 1'b0;
      sel_q <= '0;
      dec_q <= '0;
    end else begin
      hit_q <= hit_d;
      sel_q <= sel_d;
      dec_q <= dec_d;
    end
  end

  assign hit = hit_q;
  assign sel = sel_q;
  assign dec = dec_q;

endmodule

// File: tb/tb_determine_hit_unit.sv
// Directed bench for determine_hit_unit; each vector compares the packed
// {hit, sel, dec} result against a hand-computed value.
module tb_determine_hit_unit;

  logic        clk;
  logic        clr;
  logic [7:0]  addr_in;
  logic [31:0] w_addr;
  logic [7:0]  w_cnt;
  logic [3:0]  valid;
  logic [1:0]  sel;
  logic [3:0]  dec;
  logic        hit;

  int vectors;
  int miscompares;

  determine_hit_unit #(.a_width(8)) dut (
    .clk    (clk),
    .clr    (clr),
    .addr_in(addr_in),
    .w_addr (w_addr),
    .w_cnt  (w_cnt),
    .valid  (valid),
    .sel    (sel),
    .dec    (dec),
    .hit    (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp packs {hit, sel[1:0], dec[3:0]}
  task automatic check(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {hit, sel, dec};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed hit=%b sel=%0d dec=%b expected hit=%b sel=%0d dec=%b",
             tag, obs[6], obs[5:4], obs[3:0], exp[6], exp[5:4], exp[3:0]);
    end
    $display("vec %0d %s: hit=%b sel=%0d dec=%b", vectors, tag, obs[6], obs[5:4], obs[3:0]);
  endtask

  // Inputs are driven on the falling edge; one rising edge later the
  // result is sampled on the next falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clr     = 1'b0;
    addr_in = 8'h20;
    w_addr  = {8'h40, 8'h30, 8'h20, 8'h10};
    w_cnt   = 8'b11_10_01_00;
    valid   = 4'b1111;

    // Reset held with inputs that would hit: outputs must stay zero.
    #2 check("reset_t0", 7'b0_00_0000);
    cycle();
    check("reset_edge1", 7'b0_00_0000);
    cycle();
    check("reset_edge2", 7'b0_00_0000);

    // Release with nothing valid: miss, first free slot is entry 0.
    valid = 4'b0000;
    clr   = 1'b1;
    check("release_hold", 7'b0_00_0000);
    cycle();
    check("release_empty", 7'b0_00_0000);

    // Hit entry 1 (cnt 1): entries 2,3 are more recent.
    valid   = 4'b1111;
    w_cnt   = 8'b11_10_01_00;
    addr_in = 8'h20;
    check("latency_hold", 7'b0_00_0000);
    cycle();
    check("hit_dec", 7'b1_01_1100);

    // Miss with free slots 1 and 3: pick entry 1.
    valid   = 4'b0101;
    addr_in = 8'h55;
    cycle();
    check("miss_free", 7'b0_01_0000);

    // Full miss, counts {3,2,0,1}: LRU is entry 2.
    valid = 4'b1111;
    w_cnt = 8'b01_00_10_11;
    cycle();
    check("miss_lru", 7'b0_10_0000);

    // Full miss, counts {3,2,2,3}: minimum 2, lowest index 1.
    w_cnt = 8'b11_10_10_11;
    cycle();
    check("miss_lru_min2", 7'b0_01_0000);

    // Tag equal on an invalid entry must not hit; entry 3 is the free slot.
    valid   = 4'b0111;
    addr_in = 8'h40;
    w_cnt   = 8'b11_10_01_00;
    cycle();
    check("invalid_tag", 7'b0_11_0000);

    // Duplicate tag 0x20 at entries 1 and 3, counts {3,0,1,2}.
    valid   = 4'b1111;
    w_addr  = {8'h20, 8'h30, 8'h20, 8'h10};
    w_cnt   = 8'b10_01_00_11;
    addr_in = 8'h20;
    cycle();
    check("dup_tag", 7'b1_01_1101);

    // Hit entry 0 with entry 2 invalid: invalid entries never decrement.
    w_addr  = {8'h40, 8'h30, 8'h20, 8'h10};
    w_cnt   = 8'b11_10_01_00;
    valid   = 4'b1011;
    addr_in = 8'h10;
    cycle();
    check("hit_skip_invalid", 7'b1_00_1010);

    // Full width compare: a one-bit difference in the MSB is a miss.
    valid   = 4'b1111;
    addr_in = 8'hC0;
    cycle();
    check("msb_mismatch", 7'b0_00_0000);

    // Hit on the most recent entry: nothing ages.
    addr_in = 8'h40;
    cycle();
    check("hit_mru", 7'b1_11_0000);

    // Asynchronous clear mid-cycle drops the result immediately.
    #2 clr = 1'b0;
    #1 check("async_clr", 7'b0_00_0000);
    @(negedge clk);
    check("async_clr_hold", 7'b0_00_0000);
    clr = 1'b1;
    cycle();
    check("post_clr_reload", 7'b1_11_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/determine_hit_unit.md
DETERMINE_HIT_UNIT -- requirements
Module: determine_hit

Interface
REQ-001 Parameter: a_width, default 8, address width of the lookup address and of each entry tag.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: clr  input  1  reset, asynchronous, active-low; clears all outputs.
REQ-004 Port: addr_in  input  a_width  lookup address.
REQ-005 Port: w_addr  input  4*a_width  packed entry addresses; entry i at bits [i*a_width +: a_width].
REQ-006 Port: w_cnt  input  8  packed 2-bit LRU counts; entry i at bits [2i+1:2i]; 3 = most recent, 0 = least recent.
REQ-007 Port: valid  input  4  entry valid flags; bit i for entry i.
REQ-008 Port: sel  output  2  selected entry index.
REQ-009 Port: dec  output  4  per-entry decrement request.
REQ-010 Port: hit  output  1  1 = lookup hit, 0 = miss.

Function
REQ-011 Match: match[i] = valid[i] AND (entry i address == addr_in), all a_width bits compared.
REQ-012 hit_next = OR of match[3:0].
REQ-013 On hit, sel_next = lowest index i with match[i] = 1.
REQ-014 On miss with any valid bit 0, sel_next = lowest index with valid = 0.
REQ-015 On miss with all entries valid, sel_next = lowest index whose count equals the minimum count among the four (normally count 0).
REQ-016 On hit, dec_next[i] = valid[i] AND (cnt[i] > cnt[sel_next]) AND (i != sel_next); counts compared unsigned.
REQ-017 On miss, dec_next = 4'b0000.
REQ-018 hit, sel, dec are registered: each rising clk edge loads hit_next, sel_next, dec_next from current inputs; latency exactly 1 cycle; no enable, no handshake.
REQ-019 Outputs depend only on inputs sampled at the previous edge; no other internal state.
REQ-020 Invalid entries never match, even if their address equals addr_in.
REQ-021 Duplicate valid tags: lowest index wins (REQ-013); dec computed against that index.
REQ-022 X/Z-free inputs give X-free outputs; no latches.

Reset
REQ-023 While clr = 0: hit = 0, sel = 2'b00, dec = 4'b0000, asynchronously, irrespective of clk.
REQ-024 First rising edge with clr = 1 loads normal lookup results; clr assertion mid-operation discards the pending result immediately.

Structure
REQ-025 Shared package holds NUM_ENTRIES = 4, CNT_WIDTH = 2, SEL_WIDTH = 2 and the unpacking index helpers; a_width stays a module parameter.
REQ-026 Combinational lookup (compare, priority encode, LRU-minimum search, dec generation) sits in one always-comb block or one sub-module named determine_hit_core; a 4-bit lowest-set-bit priority encoder is a reusable helper inside it.
REQ-027 Output register stage is the only sequential logic in determine_hit.

Verification
REQ-028 Reset: clr = 0 with arbitrary inputs and toggling clk -> hit = 0, sel = 0, dec = 0; release clr, valid = 0 -> after next edge hit = 0, sel = 0, dec = 0.
REQ-029 Hit with dec: entries addr {0x10,0x20,0x30,0x40}, valid = 1111, cnt {0,1,2,3} (entries 0..3), addr_in = 0x20 -> after one edge hit = 1, sel = 1, dec = 4'b1100.
REQ-030 Miss with free slot: valid = 0101, entries 0 and 2 hold 0x10, 0x30, addr_in = 0x55 -> hit = 0, sel = 1, dec = 0000.
REQ-031 Miss, full, LRU: valid = 1111, cnt {3,2,0,1}, addr_in unmatched -> hit = 0, sel = 2, dec = 0000.
REQ-032 Invalid-entry tag: entry 3 address = addr_in = 0x40 but valid[3] = 0, other entries valid and unmatched -> hit = 0, sel = 3.
REQ-033 Hit on MRU entry: cnt {0,1,2,3}, addr_in matches entry 3 -> hit = 1, sel = 3, dec = 0000; async clr pulse mid-cycle -> outputs zero immediately.
